// File: rtl/tl_lamp_monitor.sv
// tl_lamp_monitor: safety filter between the traffic-light controller and the lamp drivers
module tl_lamp_monitor #(
    parameter int CONFLICT_CYC = 2,
    parameter int WDOG_W       = 8,
    parameter int WDOG_MAX     = 200,
    parameter int FLASH_HALF   = 8
) (
    input  logic       CK,
    input  logic       CLR,
    input  logic       GRN1,
    input  logic       YLW1,
    input  logic       RED1,
    input  logic       GRN2,
    input  logic       YLW2,
    input  logic       RED2,
    input  logic       ACK,
    output logic       LGRN1,
    output logic       LYLW1,
    output logic       LRED1,
    output logic       LGRN2,
    output logic       LYLW2,
    output logic       LRED2,
    output logic       FAULT,
    output logic [2:0] FCODE,
    output logic [1:0] STATE
);
    typedef enum logic [1:0] {S_INIT = 2'b00, S_RUN = 2'b01, S_FAULT = 2'b10} state_t;
    localparam int PW = $clog2(CONFLICT_CYC + 1);
    localparam int FW = $clog2(FLASH_HALF) + 1;
    localparam logic [5:0] ALL_RED = 6'b001001;
    localparam logic [PW-1:0] PERS_LIM = PW'(CONFLICT_CYC);
    localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_MAX);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);
    state_t state_q, state_d;
    logic [5:0] lamp_q, lamp_d, prev_q, prev_d, in_v;
    logic [PW-1:0] pers_q, pers_d, pers_inc;
    logic [WDOG_W-1:0] wdog_q, wdog_d, wdog_inc;
    logic [FW-1:0] flash_q, flash_d;
    logic phase_q, phase_d;
    logic [2:0] fcode_q, fcode_d;
    logic bad_enc, conflict, valid, skip, chg, pers_hit, wdog_hit, flash_wrap;
    assign in_v       = {GRN1, YLW1, RED1, GRN2, YLW2, RED2};
    assign bad_enc    = !$onehot(in_v[5:3]) || !$onehot(in_v[2:0]);
    assign conflict   = (in_v[5] | in_v[4]) & (in_v[2] | in_v[1]);
    assign valid      = !bad_enc && !conflict;
    // yellow skip compares against the last accepted (driven) pattern, so only valid inputs can trip it
    assign skip       = valid && ((lamp_q[5] && in_v[3]) || (lamp_q[2] && in_v[0]));
    assign chg        = in_v != prev_q;
    assign pers_inc   = pers_q + 1'b1;
    assign pers_hit   = !valid && (pers_inc >= PERS_LIM);
    assign wdog_inc   = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;
    assign wdog_hit   = !chg && (wdog_inc >= WDOG_LIM);
    assign flash_wrap = flash_q == FLASH_LAST;
    always_comb begin
        state_d = state_q;
        lamp_d  = lamp_q;
        prev_d  = prev_q;
        pers_d  = pers_q;
        wdog_d  = wdog_q;
        flash_d = flash_q;
        phase_d = phase_q;
        fcode_d = fcode_q;
        case (state_q)
            S_INIT: begin
                lamp_d = valid ? in_v : ALL_RED;
                prev_d = valid ? in_v : prev_q;
                pers_d = '0;
                wdog_d = '0;
                state_d = valid ? S_RUN : S_INIT;
            end
            S_RUN: begin
                prev_d  = in_v;
                pers_d  = valid ? '0 : pers_inc;
                wdog_d  = chg ? '0 : wdog_inc;
                lamp_d  = valid ? in_v : lamp_q;
                fcode_d = pers_hit ? (conflict ? 3'd1 : 3'd2) : skip ? 3'd4 : wdog_hit ? 3'd3 : 3'd0;
                if (fcode_d != 3'd0) begin
                    state_d = S_FAULT;
                    lamp_d  = ALL_RED;
                    flash_d = '0;
                    phase_d = 1'b1;
                end
            end
            S_FAULT: begin
                flash_d = flash_wrap ? '0 : flash_q + 1'b1;
                phase_d = flash_wrap ? !phase_q : phase_q;
                lamp_d  = {2'b00, phase_d, 2'b00, phase_d};
                if (ACK && valid) begin
                    state_d = S_INIT;
                    lamp_d  = ALL_RED;
                    prev_d  = '0;
                    pers_d  = '0;
                    wdog_d  = '0;
                    flash_d = '0;
                    phase_d = 1'b0;
                    fcode_d = 3'd0;
                end
            end
            default: state_d = S_INIT;
        endcase
    end
    always_ff @(posedge CK or negedge CLR) begin
        if (!CLR) begin
            state_q <= S_INIT;
            lamp_q  <= ALL_RED;
            prev_q  <= '0;
            pers_q  <= '0;
            wdog_q  <= '0;
            flash_q <= '0;
            phase_q <= 1'b0;
            fcode_q <= 3'd0;
        end else begin
            state_q <= state_d;
            lamp_q  <= lamp_d;
            prev_q  <= prev_d;
            pers_q  <= pers_d;
            wdog_q  <= wdog_d;
            flash_q <= flash_d;
            phase_q <= phase_d;
            fcode_q <= fcode_d;
        end
    end
    assign {LGRN1, LYLW1, LRED1, LGRN2, LYLW2, LRED2} = lamp_q;
    assign FAULT = state_q[1];
    assign FCODE = fcode_q;
    assign STATE = state_q;
endmodule
